fwft_fifo_ctrl: RTL and testbench
=================================

// Module: fwft_fifo_ctrl
// PURPOSE
//  Write/read controller that turns the dual-port async-read RAM into a
//  first-word-fall-through (FWFT) FIFO with valid/ready handshakes.
//  RAM port 0 is the write port and RAM port 1 is the read port.
//  The RAM's asynchronous read presents the head word combinationally on deq_data.
//  Sits between a producer stage and a consumer stage; the RAM is instantiated
//  beside this block, and this block owns the RAM's addresses and write enables.
// PARAMETERS
//  DWIDTH     8              data word width; must match the RAM's DWIDTH
//  AWIDTH     4              address width; must match the RAM's AWIDTH
//  DEPTH      (1<<AWIDTH)    capacity in words; fixed to a power of two
//  AF_THRESH  DEPTH-2        almost_full asserts when count >= AF_THRESH (FIFO_ALMOST_EN only)
//  AE_THRESH  2              almost_empty asserts when count <= AE_THRESH (FIFO_ALMOST_EN only)
// PORTS
//  clk           in   1         single clock; all state updates on posedge
//  rst           in   1         synchronous, active-high reset
//  flush         in   1         synchronous clear of FIFO contents
//  enq_valid     in   1         producer has a word to write
//  enq_data      in   DWIDTH    producer word
//  enq_ready     out  1         FIFO can accept a word this cycle
//  deq_valid     out  1         deq_data holds the head word
//  deq_data      out  DWIDTH    head word (= ram_q1)
//  deq_ready     in   1         consumer takes the head word this cycle
//  count         out  AWIDTH+1  number of words held, 0..DEPTH
//  ram_addr0     out  AWIDTH    RAM port-0 address (= wr_ptr)
//  ram_d0        out  DWIDTH    RAM port-0 write data (= enq_data)
//  ram_we0       out  1         RAM port-0 write enable (= enq fire)
//  ram_addr1     out  AWIDTH    RAM port-1 address (= rd_ptr)
//  ram_we1       out  1         RAM port-1 write enable; tied to 0
//  ram_q1        in   DWIDTH    RAM port-1 asynchronous read data
//  almost_full   out  1         FIFO_ALMOST_EN only
//  almost_empty  out  1         FIFO_ALMOST_EN only
// BEHAVIOUR
//  - Internal state: wr_ptr and rd_ptr [AWIDTH-1:0], cnt [AWIDTH:0].
//  - Full and empty are decoded from cnt, not from pointer compare.
//  - Reset (rst=1 at posedge): wr_ptr=0, rd_ptr=0, cnt=0.
//    While rst is high: enq_ready=0, deq_valid=0, ram_we0=0.
//  - enq_ready = !rst && (cnt != DEPTH); deq_valid = !rst && (cnt != 0).
//  - enq fire = enq_valid & enq_ready & !flush; ram_we0 = enq fire.
//    On fire, wr_ptr increments at the posedge.
//  - deq fire = deq_valid & deq_ready & !flush; rd_ptr increments at the posedge.
//  - cnt: +1 on enq fire alone, -1 on deq fire alone, unchanged when both fire.
//  - Pointers wrap modulo DEPTH (natural AWIDTH-bit overflow).
//  - Latency: a word enqueued at edge N is visible on deq_data/deq_valid
//    after edge N (one cycle); there is no same-cycle bypass when empty.
//  - Full: enq_ready=0 even if deq_ready=1 in the same cycle (no pass-through).
//  - Empty: deq_valid=0; deq_ready is ignored; rd_ptr does not move.
//  - flush (rst has priority over flush): at the posedge, wr_ptr=rd_ptr=0 and cnt=0.
//    Any enq/deq in that cycle is dropped; ram_we0=0 while flush=1.
//  - RAM contents are never cleared. Stale data beyond cnt is don't-care;
//    deq_data is don't-care while deq_valid=0.
//  - Reset or flush mid-burst: no partial state survives; the next enqueue
//    writes address 0.
// CONFIGURATION
//  - Macro FIFO_ALMOST_EN defined:
//    almost_full = (cnt >= AF_THRESH) and almost_empty = (cnt <= AE_THRESH);
//    both are combinational from cnt.
//    Reset/flush values: almost_full=0, almost_empty=1.
//  - Macro undefined: almost_full/almost_empty ports are absent; the
//    AF_THRESH/AE_THRESH parameters are unused.
// TESTING (AWIDTH=2, DEPTH=4, DWIDTH=8)
//  1. After reset, enq A0,A1,A2,A3 on consecutive cycles with deq_ready=0
//     -> count=4, enq_ready=0, deq_valid=1, deq_data=A0.
//  2. From full, hold enq_valid=1 (data FF) and deq_ready=1 for one cycle
//     -> A0 popped, FF not written, count=3, deq_data=A1.
//  3. Empty FIFO, enq 5C
//     -> deq_valid=0 in the same cycle, deq_valid=1 with deq_data=5C next cycle.
//  4. Run 10 words through with continuous enq/deq after one pre-fill
//     -> count stays 1, output order is exact, pointers wrap past 3 without loss.
//  5. count=3, assert flush with enq_valid=1 and deq_ready=1
//     -> next cycle count=0, deq_valid=0; the next enq writes ram_addr0=0.
//  6. FIFO_ALMOST_EN, AF_THRESH=3, AE_THRESH=1: fill 0->4
//     -> almost_empty=1 at count 0..1, almost_full=1 at count 3..4.
//     Then rst mid-fill -> count=0, almost_empty=1.

Source files
------------

// File: rtl/fwft_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for the FWFT FIFO controller.
// A word moves when valid and ready are both high at a rising clock edge.
interface fwft_fifo_ctrl_if #(
    parameter int DWIDTH = 8
);
    logic              enq_valid;
    logic [DWIDTH-1:0] enq_data;
    logic              enq_ready;
    logic              deq_valid;
    logic [DWIDTH-1:0] deq_data;
    logic              deq_ready;

    // master: the producer/consumer side of the FIFO
    modport master (
        output enq_valid, enq_data, deq_ready,
        input  enq_ready, deq_valid, deq_data
    );

    // slave: the FIFO controller itself
    modport slave (
        input  enq_valid, enq_data, deq_ready,
        output enq_ready, deq_valid, deq_data
    );
endinterface

// File: rtl/fwft_fifo_ctrl.sv
// FWFT FIFO controller driving an external dual-port RAM with asynchronous read.
// Define FIFO_ALMOST_EN to add the almost_full / almost_empty flags.
module fwft_fifo_ctrl #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
`ifdef FIFO_ALMOST_EN
    ,
    parameter int AF_THRESH = (1 << AWIDTH) - 2,
    parameter int AE_THRESH = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    fwft_fifo_ctrl_if.slave   bus,
    output logic [AWIDTH:0]   count,
    output logic [AWIDTH-1:0] ram_addr0,
    output logic [DWIDTH-1:0] ram_d0,
    output logic              ram_we0,
    output logic [AWIDTH-1:0] ram_addr1,
    output logic              ram_we1,
    input  logic [DWIDTH-1:0] ram_q1
`ifdef FIFO_ALMOST_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0]   FULL_CNT = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   cnt;
    logic              enq_fire;
    logic              deq_fire;

    // Full/empty come from the occupancy counter so a full FIFO is never mistaken for empty.
    assign bus.enq_ready = !rst && (cnt != FULL_CNT);
    assign bus.deq_valid = !rst && (cnt != '0);
    assign bus.deq_data  = ram_q1;

    assign enq_fire = bus.enq_valid && bus.enq_ready && !flush;
    assign deq_fire = bus.deq_valid && bus.deq_ready && !flush;

    assign ram_addr0 = wr_ptr;
    assign ram_d0    = bus.enq_data;
    assign ram_we0   = enq_fire;
    assign ram_addr1 = rd_ptr;
    assign ram_we1   = 1'b0;
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PTR_ONE;
            if (deq_fire) rd_ptr <= rd_ptr + PTR_ONE;
            case ({enq_fire, deq_fire})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef FIFO_ALMOST_EN
    localparam logic [AWIDTH:0] AF_CNT = (AWIDTH + 1)'(AF_THRESH);
    localparam logic [AWIDTH:0] AE_CNT = (AWIDTH + 1)'(AE_THRESH);

    // Held at their cleared values while rst is high, before cnt has been zeroed.
    assign almost_full  = !rst && (cnt >= AF_CNT);
    assign almost_empty = rst || (cnt <= AE_CNT);
`endif
endmodule

// File: tb/tb_fwft_fifo_ctrl.sv
// Self-checking bench for fwft_fifo_ctrl with AWIDTH=2 / DEPTH=4 and a behavioural async-read RAM.
// Build with FIFO_ALMOST_EN defined to also check the almost flags (AF_THRESH=3, AE_THRESH=1).
module tb_fwft_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [AW:0]   count;
    logic [AW-1:0] ram_addr0;
    logic [DW-1:0] ram_d0;
    logic          ram_we0;
    logic [AW-1:0] ram_addr1;
    logic          ram_we1;
    logic [DW-1:0] ram_q1;
`ifdef FIFO_ALMOST_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    int total = 0;
    int bad = 0;

    fwft_fifo_ctrl_if #(.DWIDTH(DW)) bus ();

`ifdef FIFO_ALMOST_EN
    fwft_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .AF_THRESH(3), .AE_THRESH(1)) dut (
`else
    fwft_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
`endif
        .clk(clk), .rst(rst), .flush(flush), .bus(bus), .count(count),
        .ram_addr0(ram_addr0), .ram_d0(ram_d0), .ram_we0(ram_we0),
        .ram_addr1(ram_addr1), .ram_we1(ram_we1), .ram_q1(ram_q1)
`ifdef FIFO_ALMOST_EN
        , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
    );

    // clock / RAM model
    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (ram_we0) mem[ram_addr0] <= ram_d0;
    assign ram_q1 = mem[ram_addr1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard and reference model, sampled on the falling edge
    logic [DW-1:0] exp_q[$];
    int            mcnt = 0;
    logic [AW-1:0] mwr = '0;
    logic [AW-1:0] mrd = '0;

    always @(negedge clk) begin
        logic ef, df;
        ef = !rst && !flush && bus.enq_valid && (mcnt != DEPTH);
        df = !rst && !flush && bus.deq_ready && (mcnt != 0);
        chk("enq_ready", bus.enq_ready, !rst && (mcnt != DEPTH));
        chk("deq_valid", bus.deq_valid, !rst && (mcnt != 0));
        chk("count", count, mcnt);
        chk("ram_we0", ram_we0, ef);
        chk("ram_we1", ram_we1, 0);
`ifdef FIFO_ALMOST_EN
        chk("almost_full", almost_full, !rst && (mcnt >= 3));
        chk("almost_empty", almost_empty, rst || (mcnt <= 1));
`endif
        if (ef) chk("ram_addr0", ram_addr0, mwr);
        if (!rst && mcnt != 0) chk("ram_addr1", ram_addr1, mrd);
        if (df) begin
            if (exp_q.size() == 0) chk("deq_q_empty", 0, 1);
            else chk("deq_data", bus.deq_data, exp_q.pop_front());
        end
        if (ef) exp_q.push_back(bus.enq_data);
        if (rst || flush) begin
            exp_q.delete();
            mcnt = 0;
            mwr = '0;
            mrd = '0;
        end else begin
            if (ef) mwr = mwr + 1'b1;
            if (df) mrd = mrd + 1'b1;
            mcnt = mcnt + (ef ? 1 : 0) - (df ? 1 : 0);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b0;
        flush = 1'b0;
    endtask

    task automatic enq_word(input logic [DW-1:0] d);
        bus.enq_valid = 1'b1;
        bus.enq_data  = d;
        tick();
        bus.enq_valid = 1'b0;
    endtask

    task automatic drain();
        bus.deq_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        bus.deq_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst = 1'b1;
        bus.enq_data = '0;
        idle();
        bus.enq_valid = 1'b1;
        tick();
        settle();
        chk("rst_enq_ready", bus.enq_ready, 0);
        chk("rst_we0", ram_we0, 0);
        tick();
        rst = 1'b0;
        bus.enq_valid = 1'b0;
        settle();
        chk("reset_count", count, 0);
        chk("reset_deq_valid", bus.deq_valid, 0);
        chk("reset_enq_ready", bus.enq_ready, 1);

        // fill to full without consuming
        enq_word(8'hA0); enq_word(8'hA1); enq_word(8'hA2); enq_word(8'hA3);
        settle();
        chk("t1_count", count, 4);
        chk("t1_enq_ready", bus.enq_ready, 0);
        chk("t1_deq_valid", bus.deq_valid, 1);
        chk("t1_data", bus.deq_data, 8'hA0);

        // full: simultaneous enq/deq must only pop
        bus.enq_valid = 1'b1; bus.enq_data = 8'hFF; bus.deq_ready = 1'b1;
        settle();
        chk("t2_enq_ready", bus.enq_ready, 0);
        chk("t2_we0", ram_we0, 0);
        tick();
        idle();
        settle();
        chk("t2_count", count, 3);
        chk("t2_data", bus.deq_data, 8'hA1);
        drain();
        settle();
        chk("drained_count", count, 0);

        // empty: no same-cycle bypass
        bus.enq_valid = 1'b1; bus.enq_data = 8'h5C;
        settle();
        chk("t3_same_cycle_valid", bus.deq_valid, 0);
        tick();
        bus.enq_valid = 1'b0;
        settle();
        chk("t3_next_valid", bus.deq_valid, 1);
        chk("t3_next_data", bus.deq_data, 8'h5C);
        drain();

        // streaming with one word of pre-fill, pointers wrap several times
        enq_word(8'($urandom_range(0, 255)));
        bus.enq_valid = 1'b1; bus.deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.enq_data = 8'($urandom_range(0, 255));
            settle();
            chk("t4_count", count, 1);
            tick();
        end
        idle();
        drain();

        // flush with pending enq/deq drops both
        enq_word(8'h11); enq_word(8'h22); enq_word(8'h33);
        settle();
        chk("t5_pre_count", count, 3);
        flush = 1'b1; bus.enq_valid = 1'b1; bus.enq_data = 8'h44; bus.deq_ready = 1'b1;
        settle();
        chk("t5_flush_we0", ram_we0, 0);
        tick();
        idle();
        settle();
        chk("t5_count", count, 0);
        chk("t5_deq_valid", bus.deq_valid, 0);
        bus.enq_valid = 1'b1; bus.enq_data = 8'h77;
        settle();
        chk("t5_addr0", ram_addr0, 0);
        chk("t5_we0", ram_we0, 1);
        tick();
        bus.enq_valid = 1'b0;
        settle();
        chk("t5_data", bus.deq_data, 8'h77);
        drain();

        // reset in the middle of a fill
        enq_word(8'h01); enq_word(8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("t6_count", count, 0);
`ifdef FIFO_ALMOST_EN
        chk("t6_almost_empty", almost_empty, 1);
        chk("t6_almost_full", almost_full, 0);
`endif
        bus.enq_valid = 1'b1; bus.enq_data = 8'h9A;
        settle();
        chk("t6_addr0", ram_addr0, 0);
        tick();
        idle();

        // random traffic with occasional flush
        for (int i = 0; i < 200; i++) begin
            bus.enq_valid = 1'($urandom_range(0, 1));
            bus.enq_data  = 8'($urandom_range(0, 255));
            bus.deq_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle();
        drain();
        settle();
        chk("final_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
